// File: rtl/tone_sequencer.sv
// Table-driven tone sequencer: one shared half-period divider plays (divisor, duration) steps.
// Optional macro TONE_SEQUENCER_LOOP_EN: replay the table from step 0 until stop.
module tone_sequencer #(
    parameter int NSTEPS   = 8,
    parameter int DIV_W    = 24,
    parameter int DUR_W    = 16,
    parameter int TICK_DIV = 131072
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      wr_en,
    input  logic [$clog2(NSTEPS)-1:0] wr_addr,
    input  logic [DIV_W-1:0]          wr_div,
    input  logic [DUR_W-1:0]          wr_dur,
    output logic                      tone_out,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(NSTEPS)-1:0] step_idx
);

    localparam int AW = $clog2(NSTEPS);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NSTEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_PLAY = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     step_idx_q, step_idx_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [DIV_W-1:0]  tone_cnt_q, tone_cnt_d;
    logic [PW-1:0]     pre_q, pre_d;
    logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
    logic              tone_q, tone_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DIV_W-1:0]  div_mem [NSTEPS];
    logic [DUR_W-1:0]  dur_mem [NSTEPS];

    // Step table storage; only writable while idle, never reset.
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            div_mem[wr_addr] <= wr_div;
            dur_mem[wr_addr] <= wr_dur;
        end
    end

    // Next-state, step, divider and duration logic; stop overrides everything.
    always_comb begin
        state_d    = state_q;
        step_idx_d = step_idx_q;
        div_d      = div_q;
        dur_d      = dur_q;
        tone_cnt_d = tone_cnt_q;
        pre_d      = pre_q;
        dur_cnt_d  = dur_cnt_q;
        tone_d     = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_LOAD;
                        step_idx_d = {AW{1'b0}};
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_LOAD: begin
                    div_d      = div_mem[step_idx_q];
                    dur_d      = dur_mem[step_idx_q];
                    tone_cnt_d = {DIV_W{1'b0}};
                    pre_d      = {PW{1'b0}};
                    dur_cnt_d  = {DUR_W{1'b0}};
                    if (dur_mem[step_idx_q] == {DUR_W{1'b0}}) begin
`ifdef TONE_SEQUENCER_LOOP_EN
                        // A marker at step 0 would spin forever, so it still ends the run.
                        if (step_idx_q != {AW{1'b0}}) begin
                            step_idx_d = {AW{1'b0}};
                            state_d    = S_LOAD;
                        end else begin
                            state_d = S_DONE;
                        end
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_PLAY;
                    end
                end
                S_PLAY: begin
                    if (div_q != {DIV_W{1'b0}}) begin
                        if (tone_cnt_q == div_q) begin
                            tone_cnt_d = {DIV_W{1'b0}};
                            tone_d     = ~tone_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
                            tone_d     = tone_q;
                        end
                    end else begin
                        tone_cnt_d = {DIV_W{1'b0}};
                        tone_d     = 1'b0;
                    end
                    if (pre_q == PRE_LAST) begin
                        pre_d     = {PW{1'b0}};
                        dur_cnt_d = dur_cnt_q + {{(DUR_W-1){1'b0}}, 1'b1};
                        if (dur_cnt_d == dur_q) begin
                            tone_d = 1'b0;
                            if (step_idx_q == IDX_LAST) begin
`ifdef TONE_SEQUENCER_LOOP_EN
                                step_idx_d = {AW{1'b0}};
                                state_d    = S_LOAD;
`else
                                state_d = S_DONE;
`endif
                            end else begin
                                step_idx_d = step_idx_q + {{(AW-1){1'b0}}, 1'b1};
                                state_d    = S_LOAD;
                            end
                        end else begin
                            state_d = S_PLAY;
                        end
                    end else begin
                        pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
        busy_d = (state_d == S_LOAD) || (state_d == S_PLAY);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q    <= S_IDLE;
            step_idx_q <= {AW{1'b0}};
            div_q      <= {DIV_W{1'b0}};
            dur_q      <= {DUR_W{1'b0}};
            tone_cnt_q <= {DIV_W{1'b0}};
            pre_q      <= {PW{1'b0}};
            dur_cnt_q  <= {DUR_W{1'b0}};
            tone_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_idx_q <= step_idx_d;
            div_q      <= div_d;
            dur_q      <= dur_d;
            tone_cnt_q <= tone_cnt_d;
            pre_q      <= pre_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_q     <= tone_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tone_out = tone_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_idx_q;

endmodule
